// File: rtl/if_fetch_if.sv
// Byte-wide read bus between the fetch stage and the memory controller.
// A request is accepted, and its data is valid, in the same cycle that mem_ack_i is high.
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four little-endian byte reads
// and hands it to IF/ID, stalling the pipe until a complete instruction is ready.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall_i,
  input  logic            jump,
  input  logic [31:0]     jump_addr,
  if_fetch_if.master      mem,
  output logic [31:0]     if_pc,
  output logic [31:0]     if_inst,
  output logic            inst_valid,
  output logic            stallreq_o
);

  typedef enum logic [0:0] {SFetch, SReady} state_e;

  state_e      st;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic [1:0]  byte_cnt;
  logic        take_byte;

  // Outputs are forced idle while reset is held, independent of register contents.
  always_comb begin
    mem.mem_req_o  = rst && (st == SFetch) && !jump;
    mem.mem_addr_o = pc + {30'd0, byte_cnt};
    stallreq_o     = rst && (st == SFetch);
    inst_valid     = rst && (st == SReady);
    if_pc          = pc;
    if_inst        = inst_buf;
    take_byte      = mem.mem_ack_i && mem.mem_req_o;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      inst_buf <= '0;
      byte_cnt <= '0;
      st       <= SFetch;
    end else if (jump) begin
      // IF/ID flushes on jump, so a ready instruction is dropped rather than consumed.
      pc       <= jump_addr;
      byte_cnt <= '0;
      st       <= SFetch;
    end else begin
      unique case (st)
        SFetch: begin
          if (take_byte) begin
            inst_buf[{byte_cnt, 3'b000} +: 8] <= mem.mem_data_i;
            byte_cnt                          <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              st <= SReady;
            end
          end
        end
        SReady: begin
          if (!stall_i[1]) begin
            pc       <= pc + 32'd4;
            byte_cnt <= '0;
            st       <= SFetch;
          end
        end
        default: st <= SFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table plus hand-written reset and wrap sequences.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        inst_valid;
  logic        stallreq_o;
  logic        ack_en;

  int n_cmp  = 0;
  int n_fail = 0;

  if_fetch_if mem_bus ();

  if_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .mem        (mem_bus.master),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .inst_valid (inst_valid),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  // Memory image: 0x13,0,0,0 at 0..3, else low address byte xor 0x5A.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a == 32'd0) return 8'h13;
    if (a < 32'd4) return 8'h00;
    return a[7:0] ^ 8'h5A;
  endfunction

  // Ack is driven raw (not gated by the request) so the DUT must ignore it when not requesting.
  assign mem_bus.mem_ack_i  = ack_en;
  assign mem_bus.mem_data_i = mem_byte(mem_bus.mem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic s, input logic j,
                       input logic [31:0] ja);
    @(negedge clk);
    rst       = r;
    ack_en    = a;
    stall_i   = {4'b0000, s, 1'b0};
    jump      = j;
    jump_addr = ja;
    #1;
  endtask

  typedef struct {
    logic        ack;
    logic        stl;
    logic        jmp;
    logic [31:0] jaddr;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        sreq;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic stl, input logic jmp,
                              input logic [31:0] jaddr, input logic req,
                              input logic [31:0] addr, input logic valid, input logic sreq,
                              input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v.ack = ack; v.stl = stl; v.jmp = jmp; v.jaddr = jaddr; v.req = req;
    v.addr = addr; v.valid = valid; v.sreq = sreq; v.pc = pc; v.inst = inst;
    return v;
  endfunction

  vec_t vecs[27];

  initial begin
    // ack stl jmp jaddr        req addr          vld sreq pc            inst
    vecs[0]  = mk(1, 0, 0, 32'h0,   1, 32'h0,   0, 1, 32'h0,   32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,   1, 32'h1,   0, 1, 32'h0,   32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,   1, 32'h2,   0, 1, 32'h0,   32'h0);
    vecs[3]  = mk(1, 0, 0, 32'h0,   1, 32'h3,   0, 1, 32'h0,   32'h0);
    vecs[4]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   32'h0000_0013);
    vecs[5]  = mk(1, 0, 0, 32'h0,   1, 32'h4,   0, 1, 32'h4,   32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0,   1, 32'h5,   0, 1, 32'h4,   32'h0);
    vecs[7]  = mk(0, 0, 0, 32'h0,   1, 32'h5,   0, 1, 32'h4,   32'h0);
    vecs[8]  = mk(0, 0, 0, 32'h0,   1, 32'h5,   0, 1, 32'h4,   32'h0);
    vecs[9]  = mk(1, 0, 0, 32'h0,   1, 32'h5,   0, 1, 32'h4,   32'h0);
    vecs[10] = mk(1, 0, 0, 32'h0,   1, 32'h6,   0, 1, 32'h4,   32'h0);
    vecs[11] = mk(1, 0, 0, 32'h0,   1, 32'h7,   0, 1, 32'h4,   32'h0);
    vecs[12] = mk(1, 1, 0, 32'h0,   0, 32'h4,   1, 0, 32'h4,   32'h5D5C_5F5E);
    vecs[13] = mk(1, 1, 0, 32'h0,   0, 32'h4,   1, 0, 32'h4,   32'h5D5C_5F5E);
    vecs[14] = mk(1, 1, 0, 32'h0,   0, 32'h4,   1, 0, 32'h4,   32'h5D5C_5F5E);
    vecs[15] = mk(1, 1, 0, 32'h0,   0, 32'h4,   1, 0, 32'h4,   32'h5D5C_5F5E);
    vecs[16] = mk(1, 1, 0, 32'h0,   0, 32'h4,   1, 0, 32'h4,   32'h5D5C_5F5E);
    vecs[17] = mk(1, 0, 0, 32'h0,   0, 32'h4,   1, 0, 32'h4,   32'h5D5C_5F5E);
    vecs[18] = mk(1, 0, 0, 32'h0,   1, 32'h8,   0, 1, 32'h8,   32'h0);
    vecs[19] = mk(1, 0, 0, 32'h0,   1, 32'h9,   0, 1, 32'h8,   32'h0);
    vecs[20] = mk(1, 0, 1, 32'h100, 0, 32'hA,   0, 1, 32'h8,   32'h0);
    vecs[21] = mk(1, 0, 0, 32'h0,   1, 32'h100, 0, 1, 32'h100, 32'h0);
    vecs[22] = mk(1, 0, 0, 32'h0,   1, 32'h101, 0, 1, 32'h100, 32'h0);
    vecs[23] = mk(1, 0, 0, 32'h0,   1, 32'h102, 0, 1, 32'h100, 32'h0);
    vecs[24] = mk(1, 0, 0, 32'h0,   1, 32'h103, 0, 1, 32'h100, 32'h0);
    vecs[25] = mk(1, 0, 1, 32'h200, 0, 32'h100, 1, 0, 32'h100, 32'h5958_5B5A);
    vecs[26] = mk(1, 0, 0, 32'h0,   1, 32'h200, 0, 1, 32'h200, 32'h0);

    rst = 1'b0; ack_en = 1'b0; stall_i = '0; jump = 1'b0; jump_addr = '0;

    // Reset held: outputs idle, registers at reset values.
    drive(0, 1, 0, 0, 32'h0);
    check("rst_req", {31'd0, mem_bus.mem_req_o}, 32'd0);
    check("rst_sreq", {31'd0, stallreq_o}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);

    foreach (vecs[i]) begin
      drive(1, vecs[i].ack, vecs[i].stl, vecs[i].jmp, vecs[i].jaddr);
      check($sformatf("v%0d_req", i), {31'd0, mem_bus.mem_req_o}, {31'd0, vecs[i].req});
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_sreq", i), {31'd0, stallreq_o}, {31'd0, vecs[i].sreq});
      check($sformatf("v%0d_pc", i), if_pc, vecs[i].pc);
      if (vecs[i].req) check($sformatf("v%0d_addr", i), mem_bus.mem_addr_o, vecs[i].addr);
      if (vecs[i].valid) check($sformatf("v%0d_inst", i), if_inst, vecs[i].inst);
    end

    // Mid-fetch reset at pc 0x20 after two bytes.
    drive(1, 1, 0, 1, 32'h20);
    check("jr_req", {31'd0, mem_bus.mem_req_o}, 32'd0);
    drive(1, 1, 0, 0, 32'h0);
    check("jr_pc", if_pc, 32'h20);
    check("jr_addr0", mem_bus.mem_addr_o, 32'h20);
    drive(1, 1, 0, 0, 32'h0);
    check("jr_addr1", mem_bus.mem_addr_o, 32'h21);
    drive(0, 1, 0, 0, 32'h0);
    check("mr_req", {31'd0, mem_bus.mem_req_o}, 32'd0);
    check("mr_sreq", {31'd0, stallreq_o}, 32'd0);
    check("mr_valid", {31'd0, inst_valid}, 32'd0);
    drive(0, 1, 0, 0, 32'h0);
    check("mr_pc", if_pc, 32'h0);
    check("mr_req2", {31'd0, mem_bus.mem_req_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 32'h0);
      check($sformatf("rs_addr%0d", k), mem_bus.mem_addr_o, k);
      check($sformatf("rs_req%0d", k), {31'd0, mem_bus.mem_req_o}, 32'd1);
    end
    drive(1, 1, 0, 1, 32'hFFFF_FFFE);
    check("rs_valid", {31'd0, inst_valid}, 32'd1);
    check("rs_inst", if_inst, 32'h0000_0013);

    // Byte address and PC wrap past 2^32.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 32'h0);
      check($sformatf("wr_addr%0d", k), mem_bus.mem_addr_o, 32'hFFFF_FFFE + k);
    end
    drive(1, 1, 0, 0, 32'h0);
    check("wr_valid", {31'd0, inst_valid}, 32'd1);
    check("wr_pc", if_pc, 32'hFFFF_FFFE);
    check("wr_inst", if_inst, 32'h0013_A5A4);
    drive(1, 1, 0, 0, 32'h0);
    check("wr_next_pc", if_pc, 32'h2);
    check("wr_next_addr", mem_bus.mem_addr_o, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
